// File: rtl/wb_trace_pkg.sv
// Shared types for the write-back commit tracer: FSM encoding, entry layout and MISR feedback tap.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int unsigned ENTRY_REG_W  = 5;
  localparam int unsigned ENTRY_DATA_W = 32;

  // Storage word layout: destination register in the upper bits, data below.
  typedef struct packed {
    logic [ENTRY_REG_W-1:0]  rd;
    logic [ENTRY_DATA_W-1:0] data;
  } entry_t;

  // Feedback bit of the signature register: XOR of its two most significant bits.
  function automatic logic misr_tap(input logic [63:0] sig, input int unsigned width);
    logic [5:0] hi;
    hi = 6'(width - 1);
    return sig[hi] ^ sig[hi - 6'd1];
  endfunction

endpackage

// File: rtl/wb_trace_ram.sv
// Trace storage: DEPTH words, registered write port and combinational read port.
module wb_trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 37
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back commit tracer: circular capture around a trigger, oldest-first valid/ready drain.
// Optional MISR signature on stored commits when WB_TRACE_SIGNATURE_EN is defined.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned SKIP_R0   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [REG_W-1:0]         wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     arm,
  input  logic                     trig,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [REG_W-1:0]         rd_reg,
  output logic [DATA_W-1:0]        rd_data,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         commit_count,
  output logic [DATA_W-1:0]        sig
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  state_e             state_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, post_q;
  logic [CW-1:0]      count_q;
  logic               overflow_q;
  logic [CNT_W-1:0]   commit_count_q;

  logic                    storable, capturing, restart, ram_we, full;
  logic [REG_W+DATA_W-1:0] ram_rdata;

  assign storable  = wb_valid && !((SKIP_R0 != 0) && (wb_rd == '0));
  assign capturing = (state_q == ST_CAPTURE) || (state_q == ST_POST);
  // arm is ignored only while draining
  assign restart   = arm && (state_q != ST_DONE);
  assign ram_we    = storable && capturing && !arm;
  assign full      = (count_q == CW'(DEPTH));

  wb_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REG_W + DATA_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({wb_rd, wb_data}),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      post_q         <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      commit_count_q <= '0;
    end else begin
      if (wb_valid) commit_count_q <= commit_count_q + CNT_W'(1);
      if (restart) begin
        state_q    <= ST_CAPTURE;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        post_q     <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_CAPTURE, ST_POST: begin
            if (ram_we) begin
              wr_ptr_q <= wr_ptr_q + PTR_W'(1);
              if (full) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                overflow_q <= 1'b1;
              end else begin
                count_q <= count_q + CW'(1);
              end
            end
            if (state_q == ST_CAPTURE) begin
              if (trig) begin
                if (POST_TRIG == 0) begin
                  state_q <= ST_DONE;
                end else begin
                  state_q <= ST_POST;
                  post_q  <= PTR_W'(POST_TRIG);
                end
              end
            end else if (ram_we) begin
              post_q <= post_q - PTR_W'(1);
              if (post_q == PTR_W'(1)) state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (count_q == '0) begin
              state_q <= ST_IDLE;
            end else if (rd_ready) begin
              rd_ptr_q <= rd_ptr_q + PTR_W'(1);
              count_q  <= count_q - CW'(1);
              if (count_q == CW'(1)) state_q <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef WB_TRACE_SIGNATURE_EN
  logic [DATA_W-1:0] sig_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= '0;
    end else if (restart) begin
      sig_q <= '0;
    end else if (ram_we) begin
      sig_q <= {sig_q[DATA_W-2:0], misr_tap(64'(sig_q), DATA_W)} ^ wb_data;
    end
  end

  assign sig = sig_q;
`else
  assign sig = '0;
`endif

  assign rd_valid     = (state_q == ST_DONE) && (count_q != '0);
  assign rd_reg       = rd_valid ? ram_rdata[DATA_W +: REG_W] : '0;
  assign rd_data      = rd_valid ? ram_rdata[DATA_W-1:0] : '0;
  assign state        = state_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign commit_count = commit_count_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: vector table, directed corner sequences and a random run
// checked against a queue-based reference model.
module tb_wb_trace_buffer;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned POST_TRIG = 8;
  localparam int unsigned CNT_W     = 32;

  logic              clk = 1'b0;
  logic              reset, wb_valid, arm, trig, rd_ready;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              rd_valid, overflow;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rd_data, sig;
  logic [1:0]        state;
  logic [4:0]        count;
  logic [CNT_W-1:0]  commit_count;

  int vectors    = 0;
  int miscompares = 0;

  wb_trace_buffer #(
    .DATA_W    (DATA_W),
    .REG_W     (REG_W),
    .DEPTH     (DEPTH),
    .POST_TRIG (POST_TRIG),
    .CNT_W     (CNT_W),
    .SKIP_R0   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .arm          (arm),
    .trig         (trig),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_reg       (rd_reg),
    .rd_data      (rd_data),
    .state        (state),
    .count        (count),
    .overflow     (overflow),
    .commit_count (commit_count),
    .sig          (sig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the rising edge with inputs idle.
  task automatic cyc(input logic v, input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d,
                     input logic a, input logic t, input logic r);
    @(negedge clk);
    wb_valid = v; wb_rd = rd; wb_data = d; arm = a; trig = t; rd_ready = r;
    @(posedge clk);
    #1;
    wb_valid = 1'b0; arm = 1'b0; trig = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; wb_valid = 1'b0; arm = 1'b0; trig = 1'b0; rd_ready = 1'b0;
    wb_rd = '0; wb_data = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_mode, m_post;
  int unsigned m_cc;
  bit          m_ovf;
  logic [DATA_W-1:0] m_sig;

  task automatic model_reset();
    mq.delete(); m_mode = 0; m_post = 0; m_cc = 0; m_ovf = 0; m_sig = '0;
  endtask

  task automatic model_push(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    mq.push_back('{rd: rd, data: d});
    if (mq.size() > DEPTH) begin
      void'(mq.pop_front());
      m_ovf = 1;
    end
`ifdef WB_TRACE_SIGNATURE_EN
    m_sig = {m_sig[DATA_W-2:0], m_sig[DATA_W-1] ^ m_sig[DATA_W-2]} ^ d;
`endif
  endtask

  task automatic model_step(input logic v, input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d,
                            input logic a, input logic t, input logic r);
    bit st;
    if (v) m_cc++;
    st = v && (rd != 0);
    if (a && m_mode != 3) begin
      mq.delete(); m_ovf = 0; m_mode = 1; m_sig = '0; m_post = 0;
      return;
    end
    case (m_mode)
      1: begin
        if (st) model_push(rd, d);
        if (t) begin
          if (POST_TRIG == 0) m_mode = 3;
          else begin m_mode = 2; m_post = POST_TRIG; end
        end
      end
      2: if (st) begin
        model_push(rd, d);
        m_post--;
        if (m_post == 0) m_mode = 3;
      end
      3: begin
        if (mq.size() == 0) m_mode = 0;
        else if (r) begin
          void'(mq.pop_front());
          if (mq.size() == 0) m_mode = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_model();
    bit   ev;
    ent_t e;
    ev = (m_mode == 3) && (mq.size() != 0);
    e  = ev ? mq[0] : '0;
    chk("rand state", 64'(state), 64'(m_mode));
    chk("rand count", 64'(count), 64'(mq.size()));
    chk("rand overflow", 64'(overflow), 64'(m_ovf));
    chk("rand commit_count", 64'(commit_count), 64'(m_cc));
    chk("rand rd_valid", 64'(rd_valid), 64'(ev));
    chk("rand rd_reg", 64'(rd_reg), 64'(e.rd));
    chk("rand rd_data", 64'(rd_data), 64'(e.data));
    chk("rand sig", 64'(sig), 64'(m_sig));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              v;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic              a, t, r;
    logic [1:0]        e_state;
    logic [4:0]        e_count;
    logic              e_rv;
    logic [REG_W-1:0]  e_reg;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  vec_t tbl[25];

  initial begin
    int          exp_q[$];
    int unsigned cc;
    logic        v, a, t, r;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] d;

    // Capture of 12 commits (trigger on the 4th, 8 post commits), then a full drain.
    tbl[0] = '{v: 0, rd: 0, data: 0, a: 1, t: 0, r: 0,
               e_state: 1, e_count: 0, e_rv: 0, e_reg: 0, e_data: 0};
    for (int k = 1; k <= 12; k++)
      tbl[k] = '{v: 1, rd: REG_W'(k), data: DATA_W'(k * 17), a: 0, t: (k == 4), r: 0,
                 e_state: (k < 4) ? 2'd1 : (k < 12) ? 2'd2 : 2'd3, e_count: 5'(k),
                 e_rv: (k == 12), e_reg: (k == 12) ? 5'd1 : 5'd0,
                 e_data: (k == 12) ? 32'd17 : 32'd0};
    for (int j = 1; j <= 12; j++)
      tbl[12 + j] = '{v: 0, rd: 0, data: 0, a: 0, t: 0, r: 1,
                      e_state: (j == 12) ? 2'd0 : 2'd3, e_count: 5'(12 - j), e_rv: (j < 12),
                      e_reg: (j < 12) ? REG_W'(j + 1) : '0,
                      e_data: (j < 12) ? DATA_W'((j + 1) * 17) : '0};

    reset = 1'b0; wb_valid = 1'b0; arm = 1'b0; trig = 1'b0; rd_ready = 1'b0;
    wb_rd = '0; wb_data = '0;
    #12;
    chk("reset state", 64'(state), 0);
    chk("reset count", 64'(count), 0);
    chk("reset overflow", 64'(overflow), 0);
    chk("reset commit_count", 64'(commit_count), 0);
    chk("reset rd_valid", 64'(rd_valid), 0);
    chk("reset rd_data", 64'(rd_data), 0);
    chk("reset sig", 64'(sig), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].v, tbl[i].rd, tbl[i].data, tbl[i].a, tbl[i].t, tbl[i].r);
      chk($sformatf("tbl[%0d] state", i), 64'(state), 64'(tbl[i].e_state));
      chk($sformatf("tbl[%0d] count", i), 64'(count), 64'(tbl[i].e_count));
      chk($sformatf("tbl[%0d] rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rv));
      chk($sformatf("tbl[%0d] rd_reg", i), 64'(rd_reg), 64'(tbl[i].e_reg));
      chk($sformatf("tbl[%0d] rd_data", i), 64'(rd_data), 64'(tbl[i].e_data));
    end

    // Asynchronous reset in POST with 5 entries held.
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(1, REG_W'(i), DATA_W'(i), 0, (i == 5), 0);
    chk("midreset pre state", 64'(state), 2);
    chk("midreset pre count", 64'(count), 5);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset state", 64'(state), 0);
    chk("midreset count", 64'(count), 0);
    chk("midreset overflow", 64'(overflow), 0);
    chk("midreset commit_count", 64'(commit_count), 0);
    chk("midreset rd_valid", 64'(rd_valid), 0);
    @(negedge clk);
    reset = 1'b1;

    // Wrap: 20 commits, trigger, 8 commits -> last 16 of 28 kept.
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 20; i++) cyc(1, 5'd5, DATA_W'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 21; i <= 28; i++) cyc(1, 5'd5, DATA_W'(i), 0, 0, 0);
    chk("wrap state", 64'(state), 3);
    chk("wrap overflow", 64'(overflow), 1);
    chk("wrap count", 64'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("wrap rd_valid", 64'(rd_valid), 1);
      chk($sformatf("wrap rd_data[%0d]", i), 64'(rd_data), 64'(13 + i));
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("wrap end state", 64'(state), 0);
    chk("wrap end count", 64'(count), 0);

    // Register-0 filtering: r0 commits counted but never stored.
    do_reset();
    cc = 0;
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 1) begin cyc(1, 5'd3, DATA_W'(i), 0, 0, 0); exp_q.push_back(i); end
      else cyc(1, 5'd0, 32'hDEAD, 0, 0, 0);
      cc++;
    end
    cyc(1, 5'd0, 32'hDEAD, 0, 1, 0);
    cc++;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) begin cyc(1, 5'd3, DATA_W'(100 + i), 0, 0, 0); exp_q.push_back(100 + i); end
      else cyc(1, 5'd0, 32'hDEAD, 0, 0, 0);
      cc++;
    end
    chk("r0 state", 64'(state), 3);
    chk("r0 count", 64'(count), 64'(exp_q.size()));
    chk("r0 commit_count", 64'(commit_count), 64'(cc));
    for (int j = 0; j < 14; j++) begin
      chk("r0 rd_reg", 64'(rd_reg), 3);
      chk($sformatf("r0 rd_data[%0d]", j), 64'(rd_data), 64'(exp_q[j]));
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("r0 end state", 64'(state), 0);

    // Back-pressure holds the head entry; arm is ignored in DONE.
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 5'd7, DATA_W'(32'hA0 + i), 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 5'd7, DATA_W'(32'hB0 + i), 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("hold state", 64'(state), 3);
      chk("hold count", 64'(count), 11);
      chk("hold rd_data", 64'(rd_data), 64'h A0);
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("done arm state", 64'(state), 3);
    chk("done arm count", 64'(count), 11);

    // Restart during POST discards the same-cycle commit.
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 5'd9, DATA_W'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cyc(1, 5'd9, DATA_W'(i), 0, 0, 0);
    chk("rearm pre state", 64'(state), 2);
    chk("rearm pre count", 64'(count), 6);
    cyc(1, 5'd9, 32'h55, 1, 0, 0);
    chk("rearm state", 64'(state), 1);
    chk("rearm count", 64'(count), 0);
    chk("rearm overflow", 64'(overflow), 0);
    cyc(1, 5'd9, 32'h77, 0, 0, 0);
    chk("rearm next count", 64'(count), 1);

    // Signature on two stored commits.
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 5'd1, 32'h1, 0, 0, 0);
`ifdef WB_TRACE_SIGNATURE_EN
    chk("sig after 0x1", 64'(sig), 64'h1);
`else
    chk("sig after 0x1", 64'(sig), 64'h0);
`endif
    cyc(1, 5'd2, 32'h2, 0, 0, 0);
    chk("sig after 0x2", 64'(sig), 64'h0);
    cyc(1, 5'd2, 32'h4, 0, 0, 0);
`ifdef WB_TRACE_SIGNATURE_EN
    chk("sig after 0x4", 64'(sig), 64'h4);
`else
    chk("sig after 0x4", 64'(sig), 64'h0);
`endif

    // Random run against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      check_model();
      v  = ($urandom_range(0, 9) < 6);
      rd = REG_W'($urandom_range(0, 3));
      d  = DATA_W'($urandom);
      a  = ($urandom_range(0, 63) == 0);
      t  = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 1) == 1);
      wb_valid = v; wb_rd = rd; wb_data = d; arm = a; trig = t; rd_ready = r;
      model_step(v, rd, d, a, t, r);
    end
    @(negedge clk);
    check_model();
    wb_valid = 1'b0; arm = 1'b0; trig = 1'b0; rd_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
